// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared constants, FSM states and fetch record for the instruction fetch unit
package ifu_fetch_pkg;

    localparam logic [31:0] INST_NOP     = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_STALL = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
    } fetch_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {inst,addr} holding buffer for a response that arrives while IF/ID is stalled
module fetch_skid_buf
    import ifu_fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   drain,
    input  logic   clear,
    input  fetch_t d,
    output fetch_t q,
    output logic   full
);

    // clear wins over load so a redirect never leaves a wrong-path entry behind
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q    <= '{inst: INST_NOP, addr: ZERO_WORD};
            full <= 1'b0;
        end else if (load) begin
            q    <= d;
            full <= 1'b1;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC owner and fetch FSM feeding the IF/ID register over a req/gnt/rvalid memory handshake
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    state_t      state;
    logic [31:0] pc;
    logic        kill;
    logic        rsp_ok;
    logic        sb_load;
    logic        sb_drain;
    logic        sb_full;
    logic        kill_next;
    fetch_t      sb_q;

    // pc already advanced on gnt, so the outstanding fetch sits one word behind it
    assign rsp_ok      = state == S_WAIT && imem_rvalid_i && !kill && !jump_en_i;
    assign sb_load     = rsp_ok && hold_i;
    assign sb_drain    = state == S_STALL && !hold_i && !jump_en_i;
    assign kill_next   = (state == S_WAIT && !imem_rvalid_i) || (state == S_REQ && imem_gnt_i);
    assign imem_req_o  = state == S_REQ;
    assign imem_addr_o = pc;

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (sb_load),
        .drain (sb_drain),
        .clear (jump_en_i),
        .d     ('{inst: imem_rdata_i, addr: pc - 32'd4}),
        .q     (sb_q),
        .full  (sb_full)
    );

    // fetch FSM, pc, squash flag and IF/ID outputs; a redirect overrides every other event
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            kill         <= 1'b0;
            inst_o       <= INST_NOP;
            inst_addr_o  <= ZERO_WORD;
            inst_valid_o <= 1'b0;
        end else if (jump_en_i) begin
            pc           <= {jump_addr_i[31:2], 2'b00};
            inst_o       <= INST_NOP;
            inst_valid_o <= 1'b0;
            kill         <= kill_next;
            state        <= kill_next ? S_WAIT : S_REQ;
        end else begin
            if (!hold_i) begin
                inst_o       <= rsp_ok ? imem_rdata_i : sb_drain ? sb_q.inst : INST_NOP;
                inst_addr_o  <= rsp_ok ? pc - 32'd4 : sb_drain ? sb_q.addr : inst_addr_o;
                inst_valid_o <= rsp_ok || (sb_drain && sb_full);
            end
            case (state)
                S_IDLE:  state <= S_REQ;
                S_REQ: begin
                    if (imem_gnt_i) begin
                        pc    <= pc + 32'd4;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        kill  <= 1'b0;
                        state <= sb_load ? S_STALL : S_REQ;
                    end
                end
                S_STALL: state <= hold_i ? S_STALL : S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: table-driven per-cycle vectors plus a reset-in-flight sequence for ifu_fetch
module tb_ifu_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        hold_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        jmp;
        logic [31:0] ja;
        logic        hold;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        req;
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] ia;
        logic        v;
    } vec_t;

    vec_t tbl[39];

    ifu_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .hold_i        (hold_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .inst_valid_o  (inst_valid_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic jmp, logic [31:0] ja, logic hold, logic gnt, logic rv, logic [31:0] rd,
                                logic req, logic [31:0] addr, logic [31:0] inst, logic [31:0] ia, logic v);
        vec_t r;
        r = '{jmp, ja, hold, gnt, rv, rd, req, addr, inst, ia, v};
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                           input logic [31:0] inst, input logic [31:0] ia, input logic v);
        chk({tag, " req"}, {31'd0, imem_req_o}, {31'd0, req});
        chk({tag, " addr"}, imem_addr_o, addr);
        chk({tag, " inst"}, inst_o, inst);
        chk({tag, " iaddr"}, inst_addr_o, ia);
        chk({tag, " valid"}, {31'd0, inst_valid_o}, {31'd0, v});
    endtask

    task automatic drive(input logic jmp, input logic [31:0] ja, input logic hold,
                         input logic gnt, input logic rv, input logic [31:0] rd);
        jump_en_i     = jmp;
        jump_addr_i   = ja;
        hold_i        = hold;
        imem_gnt_i    = gnt;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
    endtask

    initial begin
        //             jmp ja            hold gnt rv rd              req addr          inst            iaddr         v
        tbl[0]  = mk(0, 0,            0, 0, 0, 0,             0, 32'h0,        NOP,            32'h0,        0);
        tbl[1]  = mk(0, 0,            0, 1, 0, 0,             1, 32'h0,        NOP,            32'h0,        0);
        tbl[2]  = mk(0, 0,            0, 0, 1, 32'h0000_A000, 0, 32'h4,        NOP,            32'h0,        0);
        tbl[3]  = mk(0, 0,            0, 1, 0, 0,             1, 32'h4,        32'h0000_A000,  32'h0,        1);
        tbl[4]  = mk(0, 0,            0, 0, 1, 32'h0000_A004, 0, 32'h8,        NOP,            32'h0,        0);
        tbl[5]  = mk(0, 0,            0, 1, 0, 0,             1, 32'h8,        32'h0000_A004,  32'h4,        1);
        tbl[6]  = mk(0, 0,            0, 0, 1, 32'h0000_A008, 0, 32'hC,        NOP,            32'h4,        0);
        tbl[7]  = mk(0, 0,            0, 1, 0, 0,             1, 32'hC,        32'h0000_A008,  32'h8,        1);
        tbl[8]  = mk(0, 0,            0, 0, 1, 32'h0000_A00C, 0, 32'h10,       NOP,            32'h8,        0);
        tbl[9]  = mk(0, 0,            0, 0, 0, 0,             1, 32'h10,       32'h0000_A00C,  32'hC,        1);
        tbl[10] = mk(0, 0,            0, 0, 0, 0,             1, 32'h10,       NOP,            32'hC,        0);
        tbl[11] = mk(0, 0,            0, 1, 0, 0,             1, 32'h10,       NOP,            32'hC,        0);
        tbl[12] = mk(0, 0,            0, 0, 0, 0,             0, 32'h14,       NOP,            32'hC,        0);
        tbl[13] = mk(0, 0,            0, 0, 1, 32'h0000_B010, 0, 32'h14,       NOP,            32'hC,        0);
        tbl[14] = mk(1, 32'h20,       0, 0, 0, 0,             1, 32'h14,       32'h0000_B010,  32'h10,       1);
        tbl[15] = mk(0, 0,            0, 1, 0, 0,             1, 32'h20,       NOP,            32'h10,       0);
        tbl[16] = mk(0, 0,            1, 0, 1, 32'hAABB_CCDD, 0, 32'h24,       NOP,            32'h10,       0);
        tbl[17] = mk(0, 0,            1, 0, 0, 0,             0, 32'h24,       NOP,            32'h10,       0);
        tbl[18] = mk(0, 0,            0, 0, 0, 0,             0, 32'h24,       NOP,            32'h10,       0);
        tbl[19] = mk(1, 32'h40,       0, 0, 0, 0,             1, 32'h24,       32'hAABB_CCDD,  32'h20,       1);
        tbl[20] = mk(0, 0,            0, 1, 0, 0,             1, 32'h40,       NOP,            32'h20,       0);
        tbl[21] = mk(1, 32'h100,      0, 0, 0, 0,             0, 32'h44,       NOP,            32'h20,       0);
        tbl[22] = mk(0, 0,            0, 0, 1, 32'hDEAD_0040, 0, 32'h100,      NOP,            32'h20,       0);
        tbl[23] = mk(0, 0,            0, 1, 0, 0,             1, 32'h100,      NOP,            32'h20,       0);
        tbl[24] = mk(0, 0,            1, 0, 1, 32'h1111_0100, 0, 32'h104,      NOP,            32'h20,       0);
        tbl[25] = mk(1, 32'h203,      1, 0, 0, 0,             0, 32'h104,      NOP,            32'h20,       0);
        tbl[26] = mk(0, 0,            0, 1, 0, 0,             1, 32'h200,      NOP,            32'h20,       0);
        tbl[27] = mk(0, 0,            0, 0, 1, 32'h2222_0200, 0, 32'h204,      NOP,            32'h20,       0);
        tbl[28] = mk(0, 0,            0, 0, 0, 0,             1, 32'h204,      32'h2222_0200,  32'h200,      1);
        tbl[29] = mk(1, 32'hFFFF_FFFC, 0, 1, 0, 0,            1, 32'h204,      NOP,            32'h200,      0);
        tbl[30] = mk(0, 0,            0, 0, 1, 32'h3333_0204, 0, 32'hFFFF_FFFC, NOP,           32'h200,      0);
        tbl[31] = mk(0, 0,            0, 1, 0, 0,             1, 32'hFFFF_FFFC, NOP,           32'h200,      0);
        tbl[32] = mk(0, 0,            0, 0, 1, 32'h4444_FFFC, 0, 32'h0,        NOP,            32'h200,      0);
        tbl[33] = mk(0, 0,            0, 1, 0, 0,             1, 32'h0,        32'h4444_FFFC,  32'hFFFF_FFFC, 1);
        tbl[34] = mk(1, 32'h80,       0, 0, 1, 32'h5555_0004, 0, 32'h4,        NOP,            32'hFFFF_FFFC, 0);
        tbl[35] = mk(0, 0,            0, 1, 0, 0,             1, 32'h80,       NOP,            32'hFFFF_FFFC, 0);
        tbl[36] = mk(0, 0,            0, 0, 1, 32'h5555_0080, 0, 32'h84,       NOP,            32'hFFFF_FFFC, 0);
        tbl[37] = mk(0, 0,            0, 1, 0, 0,             1, 32'h84,       32'h5555_0080,  32'h80,       1);
        tbl[38] = mk(0, 0,            0, 0, 0, 0,             0, 32'h88,       NOP,            32'h80,       0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all("reset", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 39; i++) begin
            drive(tbl[i].jmp, tbl[i].ja, tbl[i].hold, tbl[i].gnt, tbl[i].rv, tbl[i].rd);
            chk_all($sformatf("row%0d", i), tbl[i].req, tbl[i].addr, tbl[i].inst, tbl[i].ia, tbl[i].v);
            @(negedge clk);
        end

        // reset while a fetch is outstanding, then a stray rvalid must not surface
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk_all("rst_wait", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 1, 32'h6666_6666);
        @(negedge clk);
        chk_all("late_rv1", 1'b1, 32'h0, NOP, 32'h0, 1'b0);
        @(negedge clk);
        chk_all("late_rv2", 1'b1, 32'h0, NOP, 32'h0, 1'b0);
        drive(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk_all("resume_wait", 1'b0, 32'h4, NOP, 32'h0, 1'b0);
        drive(0, 0, 0, 0, 1, 32'h7777_7777);
        @(negedge clk);
        chk_all("resume_data", 1'b1, 32'h4, 32'h7777_7777, 32'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
